// File: rtl/fifo_pkt_pkg.sv
// Shared state encoding and frame markers for the FIFO packetizer.
// The checksum state exists only when PKT_CHECKSUM_EN is defined.
package fifo_pkt_pkg;

  typedef logic [2:0] pkt_state_t;

  localparam pkt_state_t ST_IDLE    = 3'd0;
  localparam pkt_state_t ST_HDR     = 3'd1;
  localparam pkt_state_t ST_PAYLOAD = 3'd2;
  localparam pkt_state_t ST_TRAILER = 3'd3;
`ifdef PKT_CHECKSUM_EN
  localparam pkt_state_t ST_CKSUM   = 3'd4;
`endif

  localparam logic [7:0] HDR_MARK = 8'hA5;
  localparam logic [7:0] TRL_MARK = 8'h5A;

endpackage

// File: rtl/pkt_timeout_ctr.sv
// Idle-cycle counter; expired_o flags the cycle on which the count
// would reach TIMEOUT, so the caller can close the packet on that edge.
module pkt_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = en_i && !clear_i && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fifo_packetizer.sv
// Drains an upstream FIFO into header / payload / trailer packets.
// Define PKT_CHECKSUM_EN to append an XOR checksum word after the trailer.
module fifo_packetizer
  import fifo_pkt_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int PKT_LEN = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [15:0]      pkt_count
);

  pkt_state_t       state_q, state_d;
  logic [7:0]       seq_q, seq_d;
  logic [7:0]       len_q, len_d, lenNext;
  logic [15:0]      pktCount_q, pktCount_d;
  logic [WIDTH-1:0] hdrWord, trlWord, dataRaw;
  logic             validRaw, lastRaw, xfer, finishPkt, inPayload, expired;
`ifdef PKT_CHECKSUM_EN
  logic [WIDTH-1:0] cksum_q, cksum_d;
`endif

  always_comb begin
    hdrWord                = '0;
    hdrWord[WIDTH-1 -: 8]  = HDR_MARK;
    hdrWord[15:8]          = seq_q;
    trlWord                = '0;
    trlWord[WIDTH-1 -: 8]  = TRL_MARK;
    trlWord[15:8]          = seq_q;
    trlWord[7:0]           = len_q;
  end

  always_comb begin
    validRaw = 1'b0;
    lastRaw  = 1'b0;
    dataRaw  = '0;
    case (state_q)
      ST_HDR: begin
        validRaw = 1'b1;
        dataRaw  = hdrWord;
      end
      ST_PAYLOAD: begin
        validRaw = !fifo_empty;
        dataRaw  = fifo_dout;
      end
      ST_TRAILER: begin
        validRaw = 1'b1;
        dataRaw  = trlWord;
`ifndef PKT_CHECKSUM_EN
        lastRaw  = 1'b1;
`endif
      end
`ifdef PKT_CHECKSUM_EN
      ST_CKSUM: begin
        validRaw = 1'b1;
        dataRaw  = cksum_q;
        lastRaw  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Handshake outputs are forced low while reset is held, not just after the edge.
  assign m_valid   = rst_n & validRaw;
  assign m_last    = rst_n & lastRaw;
  assign m_data    = dataRaw;
  assign xfer      = m_valid & m_ready;
  assign inPayload = (state_q == ST_PAYLOAD);
  assign fifo_rd   = xfer & inPayload;
  assign finishPkt = xfer & m_last;
  assign lenNext   = len_q + 8'd1;
  assign pkt_count = pktCount_q;

  pkt_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (!inPayload || xfer),
    .en_i      (inPayload && fifo_empty),
    .expired_o (expired)
  );

  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    len_d      = len_q;
    pktCount_d = pktCount_q;
`ifdef PKT_CHECKSUM_EN
    cksum_d    = cksum_q;
`endif
    case (state_q)
      ST_IDLE:    if (!fifo_empty) state_d = ST_HDR;
      ST_HDR:     if (xfer) state_d = ST_PAYLOAD;
      ST_PAYLOAD: begin
        // A popped word always wins over the idle timeout.
        if (xfer) begin
          len_d = lenNext;
`ifdef PKT_CHECKSUM_EN
          cksum_d = cksum_q ^ fifo_dout;
`endif
          if (lenNext == 8'(PKT_LEN)) state_d = ST_TRAILER;
        end else if (expired) begin
          state_d = ST_TRAILER;
        end
      end
`ifdef PKT_CHECKSUM_EN
      ST_TRAILER: if (xfer) state_d = ST_CKSUM;
`endif
      default: ;
    endcase
    if (finishPkt) begin
      state_d    = ST_IDLE;
      seq_d      = seq_q + 8'd1;
      pktCount_d = pktCount_q + 16'd1;
      len_d      = '0;
`ifdef PKT_CHECKSUM_EN
      cksum_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      seq_q      <= '0;
      len_q      <= '0;
      pktCount_q <= '0;
`ifdef PKT_CHECKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      len_q      <= len_d;
      pktCount_q <= pktCount_d;
`ifdef PKT_CHECKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

endmodule
